// File: rtl/clk_en_pkg.sv
// Shared types and the divide/phase saturation rule for the clock-enable generator.
package clk_en_pkg;

  // Internal width of stored config fields; CNT_W must not exceed this.
  localparam int unsigned CLK_EN_W = 32;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOCKED = 2'd1,
    ST_APPLY  = 2'd2
  } clk_en_state_t;

  typedef struct packed {
    logic [CLK_EN_W-1:0] div;
    logic [CLK_EN_W-1:0] phase;
  } clk_en_cfg_t;

  // Divide of 0 behaves as 1; a phase past the period clamps to the last count.
  function automatic clk_en_cfg_t sat_phase(input clk_en_cfg_t cfg);
    clk_en_cfg_t eff;
    eff.div   = (cfg.div == '0) ? CLK_EN_W'(1) : cfg.div;
    eff.phase = (cfg.phase >= eff.div) ? (eff.div - CLK_EN_W'(1)) : cfg.phase;
    return eff;
  endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One strobe channel: wrapping counter, its div/phase register and the phase compare.
module clk_en_channel
  import clk_en_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  clk_en_cfg_t wr_cfg,
  output logic        hit_c
);

  clk_en_cfg_t      cfg_q;
  clk_en_cfg_t      eff_c;
  logic [CNT_W-1:0] cnt_q;

  always_comb eff_c = sat_phase(cfg_q);

  // The >= wrap also recovers cleanly when a shorter divide is written mid-count.
  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt_q       <= '0;
      cfg_q.div   <= CLK_EN_W'(DEFAULT_DIV);
      cfg_q.phase <= '0;
    end else begin
      if (wr_en) cfg_q <= wr_cfg;
      if (clr) begin
        cnt_q <= '0;
      end else if (CLK_EN_W'(cnt_q) >= (eff_c.div - CLK_EN_W'(1))) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_c = (CLK_EN_W'(cnt_q) == eff_c.phase);

endmodule

// File: rtl/multi_clk_en_gen.sv
// Multi-channel clock-enable generator: lock FSM, settle counter and config decode.
module multi_clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned DEFAULT_DIV = 2,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] strobe,
  output logic              locked
);

  localparam int unsigned SET_W = $clog2(LOCK_CYCLES);

  clk_en_state_t     state_q;
  logic [SET_W-1:0]  settle_q;
  logic              accept_c;
  logic              ch_ok_c;
  logic              write_c;
  logic              clr_c;
  clk_en_cfg_t       wr_cfg_c;
  logic [NUM_CH-1:0] hit_c;

  assign accept_c = cfg_valid && cfg_ready && (state_q != ST_APPLY);
  assign ch_ok_c  = (32'(cfg_ch) < NUM_CH);
  assign write_c  = accept_c && ch_ok_c;
  assign clr_c    = (state_q == ST_APPLY);

  always_comb begin
    wr_cfg_c.div   = CLK_EN_W'(cfg_div);
    wr_cfg_c.phase = CLK_EN_W'(cfg_phase);
  end

  // A valid write always wins over the settle-complete transition.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_SETTLE;
      settle_q  <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= accept_c && !ch_ok_c;
      cfg_ready <= 1'b1;
      case (state_q)
        ST_SETTLE: begin
          if (write_c) begin
            state_q   <= ST_APPLY;
            cfg_ready <= 1'b0;
          end else if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
            state_q <= ST_LOCKED;
            locked  <= 1'b1;
          end else begin
            settle_q <= settle_q + SET_W'(1);
          end
        end
        ST_LOCKED: begin
          if (write_c) begin
            state_q   <= ST_APPLY;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end
        end
        ST_APPLY: begin
          state_q  <= ST_SETTLE;
          settle_q <= '0;
        end
        default: begin
          state_q <= ST_SETTLE;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .refclk(refclk),
      .rst   (rst),
      .clr   (clr_c),
      .wr_en (write_c && (cfg_ch == CH_W'(i))),
      .wr_cfg(wr_cfg_c),
      .hit_c (hit_c[i])
    );
  end

  assign strobe = {NUM_CH{locked}} & hit_c;

endmodule

// File: tb/tb_multi_clk_en_gen.sv
// Directed plus random bench for multi_clk_en_gen against a time-based reference model.
module tb_multi_clk_en_gen;

  localparam int unsigned NUM_CH      = 3;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned LOCK_CYCLES = 16;
  localparam int unsigned DEFAULT_DIV = 2;

  logic              refclk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic              cfg_err;
  logic [NUM_CH-1:0] strobe;
  logic              locked;

  int checks = 0;
  int errors = 0;

  // Reference model: everything is derived from the edge at which counters were last zeroed.
  int unsigned n_edge     = 0;
  int unsigned align_edge = 0;
  bit          in_apply   = 1'b0;
  bit          ready_m    = 1'b0;
  bit          err_m      = 1'b0;
  int unsigned div_m [NUM_CH];
  int unsigned ph_m  [NUM_CH];

  multi_clk_en_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .LOCK_CYCLES(LOCK_CYCLES),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .strobe   (strobe),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, n_edge);
    end
  endtask

  task automatic check_outputs();
    bit                exp_locked;
    logic [NUM_CH-1:0] exp_strobe;
    int unsigned       ed;
    int unsigned       ep;
    exp_locked = !in_apply && ((n_edge - align_edge) >= LOCK_CYCLES);
    for (int i = 0; i < NUM_CH; i++) begin
      ed = (div_m[i] == 0) ? 1 : div_m[i];
      ep = (ph_m[i] > ed - 1) ? ed - 1 : ph_m[i];
      exp_strobe[i] = exp_locked && (((n_edge - align_edge) % ed) == ep);
    end
    chk("locked", 32'(locked), 32'(exp_locked));
    chk("cfg_ready", 32'(cfg_ready), 32'(ready_m));
    chk("cfg_err", 32'(cfg_err), 32'(err_m));
    chk("strobe", 32'(strobe), 32'(exp_strobe));
  endtask

  // Drive one edge's inputs, advance the model over that edge, then compare mid-cycle.
  task automatic step(input bit r, input bit v, input int unsigned ch,
                      input int unsigned d, input int unsigned p);
    bit acc;
    rst       = r;
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_div   = CNT_W'(d);
    cfg_phase = CNT_W'(p);
    n_edge++;
    if (r) begin
      align_edge = n_edge;
      in_apply   = 1'b0;
      ready_m    = 1'b0;
      err_m      = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_m[i] = DEFAULT_DIV;
        ph_m[i]  = 0;
      end
    end else begin
      acc   = v && ready_m;
      err_m = acc && (ch >= NUM_CH);
      if (in_apply) begin
        in_apply   = 1'b0;
        align_edge = n_edge;
        ready_m    = 1'b1;
      end else begin
        ready_m = 1'b1;
        if (acc && ch < NUM_CH) begin
          div_m[ch] = d;
          ph_m[ch]  = p;
          in_apply  = 1'b1;
          ready_m   = 1'b0;
        end
      end
    end
    @(posedge refclk);
    @(negedge refclk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;

    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);

    // Lock latency after reset release
    lat = 0;
    while (!locked && lat < 40) begin
      step(1'b0, 1'b0, 0, 0, 0);
      lat++;
    end
    chk("lock_latency", 32'(lat), 32'(LOCK_CYCLES));
    idle(12);

    // Realign with ch0 div=4 phase=1
    step(1'b0, 1'b1, 0, 4, 1);
    idle(30);

    // div 0 then div 1 on ch1: strobe every locked cycle
    step(1'b0, 1'b1, 1, 0, 5);
    idle(24);
    step(1'b0, 1'b1, 1, 1, 0);
    idle(24);

    // Phase beyond period clamps
    step(1'b0, 1'b1, 2, 3, 7);
    idle(24);

    // Nonexistent channel while locked
    step(1'b0, 1'b1, 3, 5, 0);
    idle(6);

    // Back-to-back requests with valid held through APPLY
    step(1'b0, 1'b1, 0, 5, 2);
    step(1'b0, 1'b1, 1, 6, 3);
    step(1'b0, 1'b1, 2, 2, 1);
    step(1'b0, 1'b1, 0, 3, 0);
    idle(24);

    // Single-cycle reset while locked after a config
    step(1'b1, 1'b0, 0, 0, 0);
    idle(24);

    // Random traffic including bad channels, held valids and occasional resets
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 14) == 0),
           $urandom_range(0, 3),
           $urandom_range(0, 7),
           $urandom_range(0, 9));
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_clk_en_gen.md
# multi_clk_en_gen

Parametrised multi-channel clock-enable generator with lock indication. It derives NUM_CH periodic single-cycle strobes from one reference clock and reports `locked` once its outputs are stable. Divide ratio and phase are runtime-programmable per channel through a valid/ready config port, and every accepted reconfiguration phase-realigns all channels. It sits beside the vendor PLL and supplies fabric logic with clock enables instead of extra clock domains.

## Interface
- NUM_CH, default 2: number of strobe channels (1..16).
- CNT_W, default 16: width of the divide and phase fields.
- LOCK_CYCLES, default 16: settle cycles before `locked` rises (≥2).
- DEFAULT_DIV, default 2: per-channel divide ratio after reset.
- refclk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- cfg_valid, in, 1: config request.
- cfg_ready, out, 1: config can be accepted.
- cfg_ch, in, $clog2(NUM_CH) (min 1): target channel.
- cfg_div, in, CNT_W: strobe period in refclk cycles.
- cfg_phase, in, CNT_W: counter value at which the strobe fires.
- cfg_err, out, 1: one-cycle pulse when a request targets a nonexistent channel.
- strobe, out, NUM_CH: per-channel clock enable.
- locked, out, 1: strobes valid and phase-aligned.

## Operation
- FSM states: SETTLE, LOCKED, APPLY.
- Reset (rst high at an edge) sets:
  - state SETTLE; settle counter 0.
  - all channel counters 0; div = DEFAULT_DIV; phase = 0.
  - locked = 0, cfg_ready = 0, cfg_err = 0.
- SETTLE: settle counter increments each cycle. When it equals LOCK_CYCLES-1, the next state is LOCKED.
- LOCKED: holds until a config is accepted.
- Accept condition: cfg_valid && cfg_ready, in SETTLE or LOCKED.
  - Valid cfg_ch: write div/phase for that channel; next state APPLY.
  - cfg_ch ≥ NUM_CH: no write, no state change, cfg_err pulses the next cycle.
- APPLY (one cycle): all channel counters and the settle counter are cleared; next state SETTLE.
- Channel counter:
  - Counts 0..eff_div-1, then wraps to 0.
  - eff_div = max(div, 1): div 0 and div 1 both give a strobe every cycle.
- eff_phase = min(phase, eff_div-1). A phase at or beyond the period is clamped, never lost.
- strobe[i] = locked && cnt[i] == eff_phase[i]. It is combinational from registered state and always 0 while unlocked.
- Channel counters run during SETTLE, so strobes appear already aligned when `locked` rises.
- Mid-operation reset has the same effect as reset at power-up; in-flight config is discarded.
- cfg_valid held during APPLY is not accepted, because cfg_ready is 0.

## Timing
- Cycle 0 = first rising edge with rst low.
- After cycle k (no config): cnt = k mod eff_div.
- locked goes high after edge LOCK_CYCLES-1, i.e. it is visible during cycle LOCK_CYCLES. It is registered.
- cfg_ready = registered !rst && state != APPLY. It falls the cycle after an accept and returns one cycle later.
- Accept at edge t:
  - Edge t: locked = 0 and new div/phase are in effect.
  - Edge t+1: counters = 0.
  - locked high again LOCK_CYCLES cycles after t+1.
- cfg_err: registered, high for exactly one cycle after the bad accept.
- Back-to-back configs each restart the settle count.

## Structure
- Package `clk_en_pkg`:
  - state enum `clk_en_state_t`.
  - `clk_en_cfg_t` struct {div, phase}.
  - helper `sat_phase()` implementing the eff_div/eff_phase rules.
- Sub-module `clk_en_channel`: one counter plus its div/phase register, compare, and clear input. Instantiated NUM_CH times via generate.
- The top level holds the FSM, settle counter, and config decode.

## Test plan
- Reset release, NUM_CH=2, defaults, LOCK_CYCLES=16 -> locked rises at cycle 16. strobe[0] and strobe[1] high at cycles 16, 18, 20; no strobe before 16.
- Config ch0 div=4 phase=1 accepted at edge 30 -> locked 0 from edge 30, counters 0 at 31, locked high at cycle 47. strobe[0] at cycles 48, 52; strobe[1] at cycles 47, 49.
- Config div=0, then a separate config div=1 -> strobe every locked cycle in both cases.
- Config div=3 phase=7 -> phase clamps to 2; strobe on cycles where cnt==2.
- cfg_ch=3 with NUM_CH=2 -> cfg_err one-cycle pulse; locked stays 1; strobes undisturbed.
- rst asserted for one cycle while in LOCKED after a config -> locked 0, div back to 2, cfg_ready 0 for that cycle, relock after 16 cycles.
